// File: rtl/exec_seq.sv
// Four-state instruction sequencer: captures an instruction, stages ALU operands,
// collects the external ALU result and writes it back to a 16 x 4-bit register file.
module exec_seq #(
  parameter bit DBG_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [12:0] instr,
  output logic        busy,
  output logic        done,
  output logic [3:0]  alu_a,
  output logic [3:0]  alu_b,
  output logic [2:0]  alu_sel,
  output logic        alu_cin,
  input  logic [3:0]  alu_out,
  input  logic        alu_cout,
  output logic        carry_flag,
  output logic        zero_flag,
  input  logic [3:0]  dbg_addr,
  output logic [3:0]  dbg_data
);

  localparam int DATA_W = 4;
  localparam int NREGS  = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2,
    WB    = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [12:0]       instr_p0;
  logic [DATA_W-1:0] result_p2;
  logic              cout_p2;
  logic [DATA_W-1:0] rf [NREGS];

  logic              imm_p0;
  logic              fw_p0;
  logic [2:0]        sel_p0;
  logic [3:0]        rd_p0;
  logic [3:0]        rs_p0;

  assign imm_p0 = instr_p0[12];
  assign fw_p0  = instr_p0[11];
  assign sel_p0 = instr_p0[10:8];
  assign rd_p0  = instr_p0[7:4];
  assign rs_p0  = instr_p0[3:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (start) state_nxt = FETCH;
      FETCH:   state_nxt = EXEC;
      EXEC:    state_nxt = WB;
      WB:      state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state != IDLE);

  // Stage p0: instruction capture, held until the next accept
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_p0 <= '0;
    end else if (state == IDLE && start) begin
      instr_p0 <= instr;
    end
  end

  // Stage p1: operand staging toward the external ALU
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alu_a   <= '0;
      alu_b   <= '0;
      alu_sel <= '0;
      alu_cin <= 1'b0;
    end else if (state == FETCH) begin
      alu_a   <= imm_p0 ? rs_p0 : rf[rs_p0];
      alu_b   <= rf[rd_p0];
      alu_sel <= sel_p0;
      alu_cin <= carry_flag;
    end
  end

  // Stage p2: ALU result capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      result_p2 <= '0;
      cout_p2   <= 1'b0;
    end else if (state == EXEC) begin
      result_p2 <= alu_out;
      cout_p2   <= alu_cout;
    end
  end

  // Stage p3: write-back, flag update and completion pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NREGS; i++) begin
        rf[i] <= '0;
      end
      carry_flag <= 1'b0;
      zero_flag  <= 1'b0;
      done       <= 1'b0;
    end else begin
      done <= (state == WB);
      if (state == WB) begin
        rf[rd_p0] <= result_p2;
        if (fw_p0) begin
          carry_flag <= cout_p2;
          zero_flag  <= (result_p2 == '0);
        end
      end
    end
  end

  generate
    if (DBG_EN) begin : g_dbg
      assign dbg_data = rf[dbg_addr];
    end else begin : g_no_dbg
      assign dbg_data = 4'b0000;
    end
  endgenerate

endmodule
